// File: rtl/frame_gray_pkg.sv
// Shared types and constants for the frame capture / grayscale pipeline.
// Optional build macro: GRAY_ROUND_EN selects round-to-nearest luminance
// with saturation; the default build truncates.
package frame_gray_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PROCESS = 2'd2
  } state_t;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  // Weighted luminance; coefficients sum to 256, so the 16-bit accumulator
  // never overflows and the high byte is the gray level.
  function automatic logic [7:0] gray_calc(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    logic [15:0] acc;
`ifdef GRAY_ROUND_EN
    logic [16:0] rnd;
`endif
    acc = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b);
`ifdef GRAY_ROUND_EN
    rnd = {1'b0, acc} + 17'd128;
    gray_calc = (rnd[16:8] > 9'd255) ? 8'hFF : rnd[15:8];
`else
    gray_calc = acc[15:8];
`endif
  endfunction

endpackage

// File: rtl/frame_gray_pipeline_rwm_buffer.sv
// Frame memory: sequential write during capture, registered sequential read
// during replay, with read hold while the consumer is stalled.
module rwm_buffer #(
  parameter  int PIXELS = 16,
  localparam int DEPTH  = 3 * PIXELS,
  localparam int AW     = $clog2(3 * PIXELS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic       pause,
  output logic       wr_done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam int            WR_LAST_I = DEPTH - 1;
  localparam logic [AW-1:0] WR_LAST   = WR_LAST_I[AW-1:0];
  localparam logic [AW:0]   RD_END    = DEPTH[AW:0];
  localparam logic [AW:0]   RD_ONE    = {{AW{1'b0}}, 1'b1};

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   rd_ptr;

  assign wr_done = wr_en && (wr_ptr == WR_LAST);

  // Storage array; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers and registered read port; a stall freezes the read stage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (!pause) begin
        if (rd_en && (rd_ptr < RD_END)) begin
          rd_data  <= mem[rd_ptr[AW-1:0]];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + RD_ONE;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/frame_gray_pipeline.sv
// Single-frame capture-and-convert top: control FSM plus grayscaler around
// the rwm_buffer frame memory.
// Optional build macro: GRAY_ROUND_EN (rounded, saturated luminance).
module frame_gray_pipeline
  import frame_gray_pkg::*;
#(
  parameter  int PIXELS = 16,
  localparam int AW     = $clog2(3 * PIXELS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  input  logic       gs_ready,
  output logic       camera_enable,
  output logic       rw,
  output logic       busy,
  output logic [7:0] gs_data,
  output logic       gs_valid,
  output logic       frame_done
);

  localparam int            CW         = $clog2(PIXELS + 1);
  localparam int            PIX_LAST_I = PIXELS - 1;
  localparam logic [CW-1:0] PIX_LAST   = PIX_LAST_I[CW-1:0];

  state_t        state, state_nxt;
  logic          pause, start_ok, flush, wr_en, wr_done;
  logic          consume, accept, last_accept;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [1:0]    chan;
  logic [7:0]    r_q, g_q;
  logic [CW-1:0] pix_cnt;

  assign pause       = gs_valid & ~gs_ready;
  assign start_ok    = (state == IDLE) && start;
  assign flush       = clear || start_ok;
  assign wr_en       = cam_valid && (state == CAPTURE) && !clear;
  assign consume     = rd_valid && !pause;
  assign accept      = gs_valid && gs_ready;
  assign last_accept = accept && (pix_cnt == PIX_LAST);

  rwm_buffer #(.PIXELS(PIXELS)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (cam_data),
    .rd_en    (state == PROCESS),
    .pause    (pause),
    .wr_done  (wr_done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs; clear overrides every transition.
  always_comb begin
    state_nxt     = state;
    camera_enable = 1'b0;
    rw            = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        camera_enable = 1'b1;
        busy          = 1'b1;
        if (wr_done) state_nxt = PROCESS;
      end
      PROCESS: begin
        rw   = 1'b1;
        busy = 1'b1;
        if (last_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Grayscaler: gather R,G,B, emit one gray value per pixel with handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      chan       <= CH_R;
      r_q        <= '0;
      g_q        <= '0;
      pix_cnt    <= '0;
      gs_data    <= '0;
      gs_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else if (flush) begin
      chan       <= CH_R;
      pix_cnt    <= '0;
      gs_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_accept;
      if (accept) begin
        gs_valid <= 1'b0;
        pix_cnt  <= pix_cnt + CW'(1);
      end
      // A B byte landing on the accept cycle re-arms gs_valid with new data.
      if (consume) begin
        case (chan)
          CH_R: begin
            r_q  <= rd_data;
            chan <= CH_G;
          end
          CH_G: begin
            g_q  <= rd_data;
            chan <= CH_B;
          end
          CH_B: begin
            gs_data  <= gray_calc(r_q, g_q, rd_data);
            gs_valid <= 1'b1;
            chan     <= CH_R;
          end
          default: chan <= CH_R;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_gray_pipeline.sv
// Self-checking bench for frame_gray_pipeline (PIXELS=4).
module tb_frame_gray_pipeline;

  localparam int PIXELS = 4;
  localparam int NB     = 3 * PIXELS;

  logic       clk = 1'b0;
  logic       rst, start, clear, cam_valid, gs_ready;
  logic [7:0] cam_data;
  logic       camera_enable, rw, busy, gs_valid, frame_done;
  logic [7:0] gs_data;

  int total = 0;
  int bad   = 0;

  // Monitor-owned observations.
  int         out_q[$];
  int         done_pulses = 0;
  int         stab_err    = 0;
  int         fd_err      = 0;
  logic       fd_prev     = 1'b0;
  logic       hold_pend   = 1'b0;
  logic [7:0] hold_val    = '0;

  // Frame under test and its expected gray values.
  logic [7:0] frm[NB];
  int         expv[PIXELS];

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         exp_t;
    int         exp_r;
  } vec_t;
  vec_t tbl[8];

  frame_gray_pipeline #(.PIXELS(PIXELS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .clear         (clear),
    .cam_valid     (cam_valid),
    .cam_data      (cam_data),
    .gs_ready      (gs_ready),
    .camera_enable (camera_enable),
    .rw            (rw),
    .busy          (busy),
    .gs_data       (gs_data),
    .gs_valid      (gs_valid),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Reference luminance straight from the weighted-sum definition.
  function automatic int gray_ref(input int r, input int g, input int b);
    int s;
    s = 77 * r + 150 * g + 29 * b;
`ifdef GRAY_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe the output stream mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (gs_valid === 1'b1 && gs_ready === 1'b1) out_q.push_back(int'(gs_data));
      if (hold_pend && (gs_valid !== 1'b1 || gs_data !== hold_val)) stab_err++;
      hold_pend = (gs_valid === 1'b1) && (gs_ready === 1'b0);
      hold_val  = gs_data;
      if (frame_done === 1'b1) begin
        done_pulses++;
        if (busy !== 1'b0) fd_err++;
        if (fd_prev) fd_err++;
      end
      fd_prev = (frame_done === 1'b1);
    end
  end

  // Capture frm[] and stream it back, comparing against expv[].
  task automatic run_frame(input int gap_mode, input int rdy_mode, input bit stall,
                           input bit inj_start, input bit chk_lat);
    int         base, d0, e0, f0, first_c, done_c;
    bit         got_done, stalled, injected, inj_checked;
    logic       busy_at_done;
    logic [7:0] held;
    base = out_q.size(); d0 = done_pulses; e0 = stab_err; f0 = fd_err;
    gs_ready = 1'b1;
    // Camera traffic while idle must be ignored.
    cam_valid = 1'b1; cam_data = 8'($urandom); tick();
    chk("idle_busy", busy, 0);
    cam_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("start_cam_en", camera_enable, 1);
    chk("start_busy", busy, 1);
    chk("start_rw", rw, 0);
    for (int i = 0; i < NB; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        cam_valid = 1'b0; cam_data = 8'($urandom); tick();
      end
      if (i == NB - 1) chk("pre_last_rw", rw, 0);
      cam_valid = 1'b1; cam_data = frm[i]; tick();
    end
    cam_valid = 1'b0;
    chk("post_last_rw", rw, 1);
    chk("post_last_cam_en", camera_enable, 0);
    got_done = 0; stalled = 0; injected = 0; inj_checked = 0;
    first_c = -1; done_c = -1; busy_at_done = 1'bx;
    for (int c = 0; c < 400; c++) begin
      if (frame_done === 1'b1) begin
        got_done = 1; done_c = c; busy_at_done = busy;
        break;
      end
      if (gs_valid === 1'b1 && first_c < 0) first_c = c;
      if (injected && !inj_checked) begin
        chk("start_in_process_ignored", camera_enable, 0);
        inj_checked = 1;
      end
      if (stall && !stalled && gs_valid === 1'b1) begin
        stalled = 1; held = gs_data; gs_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("stall_valid", gs_valid, 1);
          chk("stall_data", gs_data, held);
        end
        gs_ready = 1'b1;
      end else if (rdy_mode == 1) begin
        gs_ready = 1'($urandom_range(0, 1));
      end else begin
        gs_ready = 1'b1;
      end
      if (inj_start && !injected && rw === 1'b1) begin
        start = 1'b1; injected = 1;
      end else begin
        start = 1'b0;
      end
      cam_valid = 1'($urandom_range(0, 1)); cam_data = 8'($urandom);
      tick();
    end
    start = 1'b0; cam_valid = 1'b0; gs_ready = 1'b1;
    chk("frame_done_seen", got_done, 1);
    chk("busy_at_done", busy_at_done, 0);
    if (chk_lat) begin
      chk("first_gray_latency", first_c, 4);
      chk("frame_cycles", done_c, 3 * PIXELS + 2);
    end
    tick(); tick(); tick();
    chk("busy_after_done", busy, 0);
    chk("done_pulse_count", done_pulses - d0, 1);
    chk("hold_stable", stab_err - e0, 0);
    chk("done_shape", fd_err - f0, 0);
    chk("pixel_count", out_q.size() - base, PIXELS);
    for (int p = 0; p < PIXELS; p++) begin
      if (base + p < out_q.size()) chk("gray_value", out_q[base + p], expv[p]);
    end
  endtask

  task automatic load_table_frame(input int f);
    for (int k = 0; k < PIXELS; k++) begin
      frm[3*k]   = tbl[f*PIXELS + k].r;
      frm[3*k+1] = tbl[f*PIXELS + k].g;
      frm[3*k+2] = tbl[f*PIXELS + k].b;
`ifdef GRAY_ROUND_EN
      expv[k] = tbl[f*PIXELS + k].exp_r;
`else
      expv[k] = tbl[f*PIXELS + k].exp_t;
`endif
    end
  endtask

  task automatic load_random_frame();
    for (int i = 0; i < NB; i++) frm[i] = 8'($urandom);
    for (int k = 0; k < PIXELS; k++) expv[k] = gray_ref(int'(frm[3*k]), int'(frm[3*k+1]), int'(frm[3*k+2]));
  endtask

  initial begin
    //          r    g    b   trunc round
    tbl[0] = '{8'd255, 8'd255, 8'd255, 255, 255};
    tbl[1] = '{8'd255, 8'd0,   8'd0,    76,  77};
    tbl[2] = '{8'd0,   8'd255, 8'd0,   149, 149};
    tbl[3] = '{8'd0,   8'd0,   8'd255,  28,  29};
    tbl[4] = '{8'd0,   8'd0,   8'd0,     0,   0};
    tbl[5] = '{8'd100, 8'd150, 8'd200, 140, 141};
    tbl[6] = '{8'd10,  8'd20,  8'd30,   18,  18};
    tbl[7] = '{8'd128, 8'd128, 8'd128, 128, 128};

    rst = 1'b1; start = 1'b0; clear = 1'b0; cam_valid = 1'b0; cam_data = '0; gs_ready = 1'b1;
    tick(); start = 1'b1; tick(); start = 1'b0; tick();
    chk("rst_cam_en", camera_enable, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gs_data", gs_data, 0);
    chk("rst_gs_valid", gs_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0; tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cam_en", camera_enable, 0);

    // Table frames, gapless then with alternating camera gaps.
    load_table_frame(0); run_frame(0, 0, 0, 0, 1);
    load_table_frame(0); run_frame(1, 0, 0, 0, 0);
    load_table_frame(1); run_frame(0, 0, 0, 0, 1);
    load_table_frame(1); run_frame(1, 0, 0, 0, 0);

    // Back-pressure stall with a stray start during replay.
    load_table_frame(1); run_frame(0, 0, 1, 1, 0);

    // Abort mid-capture, then a fresh frame must show only new data.
    start = 1'b1; tick(); start = 1'b0;
    cam_valid = 1'b1; cam_data = 8'hAA; tick();
    cam_data = 8'h55; tick();
    cam_valid = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_busy", busy, 0);
    chk("clear_cam_en", camera_enable, 0);
    chk("clear_gs_valid", gs_valid, 0);
    load_random_frame(); run_frame(0, 0, 0, 0, 1);

    // Randomized frames against the reference model.
    for (int n = 0; n < 12; n++) begin
      load_random_frame();
      run_frame(2, 1, n % 3 == 0, n % 4 == 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
